// File: rtl/fft_sample_loader.sv
// fft_sample_loader: captures one DATA_W sample per rising edge of the
// asynchronous `switch` button into an N_SAMPLES frame buffer. When the frame
// is full it is offered to the FFT core with frame_valid/frame_ready. The core
// reads the buffer through a registered read port.
// Build option: define DEBOUNCE_EN to insert a DEBOUNCE_CYCLES debounce filter
// between the synchronizer and the edge detector.
module fft_sample_loader #(
   parameter int unsigned N_SAMPLES       = 8,
   parameter int unsigned DATA_W          = 16,
   parameter int unsigned ADDR_W          = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              switch,
   input  logic [DATA_W-1:0] data_in,
   output logic              frame_valid,
   input  logic              frame_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W:0]   sample_count,
   output logic              overrun
);

   typedef enum logic {FILL, FULL} state_t;

   localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'(N_SAMPLES - 1);

   state_t              state, state_next;
   logic [ADDR_W-1:0]   wr_ptr;
   logic [DATA_W-1:0]   mem [N_SAMPLES];
   logic                s1, s2;
   logic                step;
   logic                wr_en;
   logic                clear_frame;
   logic                set_overrun;

   // Two-flop synchronizer for the asynchronous button
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= switch;
         s2 <= s1;
      end
   end

`ifdef DEBOUNCE_EN
   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [DB_W-1:0] db_cnt;
   logic            db;
   logic            db_prev;

   // Debounce: db follows s2 only after DEBOUNCE_CYCLES consecutive disagreements
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         db_cnt  <= '0;
         db      <= 1'b0;
         db_prev <= 1'b0;
      end else begin
         db_prev <= db;
         if (s2 != db) begin
            if (db_cnt == DB_LAST) begin
               db     <= s2;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   assign step = db & ~db_prev;
`else
   logic s3;

   // History flop for rising-edge detection on the synchronized button
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s3 <= 1'b0;
      end else begin
         s3 <= s2;
      end
   end

   assign step = s2 & ~s3;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= FILL;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state and control strobes
   always_comb begin
      state_next  = state;
      wr_en       = 1'b0;
      clear_frame = 1'b0;
      set_overrun = 1'b0;
      case (state)
         FILL: begin
            if (step) begin
               wr_en = 1'b1;
               if (sample_count == LAST_COUNT) begin
                  state_next = FULL;
               end
            end
         end
         FULL: begin
            // A press coinciding with the handshake is dropped, not carried
            // into the new frame.
            if (step) begin
               set_overrun = 1'b1;
            end
            if (frame_ready) begin
               clear_frame = 1'b1;
               state_next  = FILL;
            end
         end
         default: state_next = FILL;
      endcase
   end

   // Write pointer, sample counter, frame_valid and sticky overrun
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr       <= '0;
         sample_count <= '0;
         frame_valid  <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         frame_valid <= (state_next == FULL);
         if (set_overrun) begin
            overrun <= 1'b1;
         end
         if (clear_frame) begin
            wr_ptr       <= '0;
            sample_count <= '0;
         end else if (wr_en) begin
            wr_ptr       <= wr_ptr + 1'b1;
            sample_count <= sample_count + 1'b1;
         end
      end
   end

   // Frame buffer write port; contents survive reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Registered read port; same-address write returns the old word
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed self-checking bench for fft_sample_loader (works with or without
// DEBOUNCE_EN; press timing and latency adapt to the build).
module tb_fft_sample_loader;

`ifdef DEBOUNCE_EN
   localparam int HI_NS      = 300;
   localparam int LO_NS      = 300;
   localparam int LONG_NS    = 400;
   localparam int OLD_EDGES  = 18;
`else
   localparam int HI_NS      = 22;
   localparam int LO_NS      = 22;
   localparam int LONG_NS    = 200;
   localparam int OLD_EDGES  = 2;
`endif

   logic        clk;
   logic        reset;
   logic        switch;
   logic [15:0] data_in;
   logic        frame_valid;
   logic        frame_ready;
   logic [2:0]  rd_addr;
   logic [15:0] rd_data;
   logic [3:0]  sample_count;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   fft_sample_loader #(
      .N_SAMPLES      (8),
      .DATA_W         (16),
      .ADDR_W         (3),
      .DEBOUNCE_CYCLES(16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .switch      (switch),
      .data_in     (data_in),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .sample_count(sample_count),
      .overrun     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic press(input logic [15:0] d, input int hi_ns);
      data_in = d;
      switch  = 1'b1;
      #(hi_ns);
      switch  = 1'b0;
      #(LO_NS);
   endtask

   task automatic read_word(input logic [2:0] a, output logic [15:0] d);
      @(negedge clk);
      rd_addr = a;
      @(negedge clk);
      d = rd_data;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      #1;
      checks++;
      if (sample_count !== 4'd0 || frame_valid !== 1'b0 || overrun !== 1'b0 || rd_data !== 16'h0000) begin
         errors++;
         $display("FAIL reset_state: count=%0d fv=%b ovr=%b rd=%h, want 0 0 0 0000",
                  sample_count, frame_valid, overrun, rd_data);
      end
      #21;
      reset = 1'b1;
   endtask

   task automatic test_fill;
      logic [15:0] d;
      logic [15:0] exp;
      for (int i = 0; i < 7; i++) begin
         exp = 16'h0011 * 16'(i + 1);
         press(exp, HI_NS);
         @(negedge clk);
         checks++;
         if (sample_count !== 4'(i + 1) || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_count[%0d]: count=%0d fv=%b, want %0d 0", i, sample_count, frame_valid, i + 1);
         end
      end
      // 8th press aligned to the clock: frame_valid must rise with the 8th write
      data_in = 16'h0088;
      @(negedge clk);
      switch = 1'b1;
      for (int c = 0; c < OLD_EDGES + 2; c++) begin
         @(negedge clk);
         checks++;
         if (frame_valid !== (sample_count == 4'd8)) begin
            errors++;
            $display("FAIL fill_fv_edge[%0d]: fv=%b count=%0d, want fv==(count==8)", c, frame_valid, sample_count);
         end
      end
      checks++;
      if (sample_count !== 4'd8 || frame_valid !== 1'b1) begin
         errors++;
         $display("FAIL fill_full: count=%0d fv=%b, want 8 1", sample_count, frame_valid);
      end
      #(HI_NS);
      switch = 1'b0;
      #(LO_NS);
      for (int i = 0; i < 8; i++) begin
         read_word(3'(i), d);
         exp = 16'h0011 * 16'(i + 1);
         checks++;
         if (d !== exp) begin
            errors++;
            $display("FAIL fill_read[%0d]: got %h want %h", i, d, exp);
         end
      end
   endtask

   task automatic test_overrun;
      logic [15:0] d;
      press(16'hDEAD, HI_NS);
      @(negedge clk);
      checks++;
      if (overrun !== 1'b1 || frame_valid !== 1'b1 || sample_count !== 4'd8) begin
         errors++;
         $display("FAIL overrun_flags: ovr=%b fv=%b count=%0d, want 1 1 8", overrun, frame_valid, sample_count);
      end
      read_word(3'd7, d);
      checks++;
      if (d !== 16'h0088) begin
         errors++;
         $display("FAIL overrun_buf7: got %h want 0088", d);
      end
      read_word(3'd0, d);
      checks++;
      if (d !== 16'h0011) begin
         errors++;
         $display("FAIL overrun_buf0: got %h want 0011", d);
      end
   endtask

   task automatic test_handshake;
      logic [15:0] d;
      @(negedge clk);
      frame_ready = 1'b1;
      @(negedge clk);
      frame_ready = 1'b0;
      checks++;
      if (frame_valid !== 1'b0 || sample_count !== 4'd0 || overrun !== 1'b1) begin
         errors++;
         $display("FAIL handshake: fv=%b count=%0d ovr=%b, want 0 0 1", frame_valid, sample_count, overrun);
      end
      // frame_ready while filling is ignored
      @(negedge clk);
      frame_ready = 1'b1;
      @(negedge clk);
      frame_ready = 1'b0;
      press(16'h1234, HI_NS);
      @(negedge clk);
      checks++;
      if (sample_count !== 4'd1 || frame_valid !== 1'b0 || overrun !== 1'b1) begin
         errors++;
         $display("FAIL handshake_press: count=%0d fv=%b ovr=%b, want 1 0 1", sample_count, frame_valid, overrun);
      end
      read_word(3'd0, d);
      checks++;
      if (d !== 16'h1234) begin
         errors++;
         $display("FAIL handshake_addr0: got %h want 1234", d);
      end
   endtask

   task automatic test_long_press;
      logic [15:0] d;
      press(16'hBEEF, LONG_NS);
      @(negedge clk);
      checks++;
      if (sample_count !== 4'd2) begin
         errors++;
         $display("FAIL long_press_count: got %0d want 2", sample_count);
      end
      read_word(3'd1, d);
      checks++;
      if (d !== 16'hBEEF) begin
         errors++;
         $display("FAIL long_press_addr1: got %h want beef", d);
      end
      read_word(3'd2, d);
      checks++;
      if (d !== 16'h0033) begin
         errors++;
         $display("FAIL long_press_addr2: got %h want 0033", d);
      end
   endtask

   task automatic test_latency;
      logic [15:0] d;
      data_in = 16'h5A5A;
      @(negedge clk);
      switch = 1'b1;
      for (int c = 0; c < OLD_EDGES; c++) begin
         @(negedge clk);
         checks++;
         if (sample_count !== 4'd2) begin
            errors++;
            $display("FAIL latency_early[%0d]: count=%0d want 2", c, sample_count);
         end
      end
      @(negedge clk);
      checks++;
      if (sample_count !== 4'd3) begin
         errors++;
         $display("FAIL latency_write: count=%0d want 3", sample_count);
      end
      #(HI_NS);
      switch = 1'b0;
      #(LO_NS);
      read_word(3'd2, d);
      checks++;
      if (d !== 16'h5A5A) begin
         errors++;
         $display("FAIL latency_addr2: got %h want 5a5a", d);
      end
   endtask

   task automatic test_reset_mid_fill;
      logic [15:0] d;
      @(posedge clk);
      #1;
      reset = 1'b0;
      #3;
      checks++;
      if (sample_count !== 4'd0 || frame_valid !== 1'b0 || overrun !== 1'b0 || rd_data !== 16'h0000) begin
         errors++;
         $display("FAIL midreset_clear: count=%0d fv=%b ovr=%b rd=%h, want 0 0 0 0000",
                  sample_count, frame_valid, overrun, rd_data);
      end
      #4;
      reset = 1'b1;
      press(16'h7777, HI_NS);
      @(negedge clk);
      checks++;
      if (sample_count !== 4'd1 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL midreset_press: count=%0d ovr=%b, want 1 0", sample_count, overrun);
      end
      read_word(3'd0, d);
      checks++;
      if (d !== 16'h7777) begin
         errors++;
         $display("FAIL midreset_addr0: got %h want 7777", d);
      end
      read_word(3'd1, d);
      checks++;
      if (d !== 16'hBEEF) begin
         errors++;
         $display("FAIL midreset_keep1: got %h want beef", d);
      end
   endtask

`ifdef DEBOUNCE_EN
   task automatic test_glitch;
      data_in = 16'hBAD0;
      switch  = 1'b1;
      #50;
      switch  = 1'b0;
      #(LO_NS);
      @(negedge clk);
      checks++;
      if (sample_count !== 4'd1) begin
         errors++;
         $display("FAIL glitch_rejected: count=%0d want 1", sample_count);
      end
   endtask
`endif

   initial begin
      reset       = 1'b1;
      switch      = 1'b0;
      data_in     = '0;
      frame_ready = 1'b0;
      rd_addr     = '0;
      #1;
      test_reset;
      test_fill;
      test_overrun;
      test_handshake;
      test_long_press;
      test_latency;
      test_reset_mid_fill;
`ifdef DEBOUNCE_EN
      test_glitch;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, want completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fft_sample_loader.md
Name: fft_sample_loader

Overview:
- Input-side counterpart of the FFT result stepper. The result stepper pages FFT outputs onto the 16-bit `array` display, one word per `switch` press.
- This block does the reverse. Each `switch` press captures one 16-bit sample word into an N-entry frame buffer.
- When the frame is full, it offers the buffer to the FFT core with a valid/ready handshake. The core reads the samples through a synchronous read port.

Parameters:
- N_SAMPLES, 8, frame length in samples; power of two, minimum 2.
- DATA_W, 16, sample width in bits.
- ADDR_W, 3, index width; equals log2(N_SAMPLES).
- DEBOUNCE_CYCLES, 16, stable-cycle count; used only when DEBOUNCE_EN is defined.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-low reset; clears all state immediately, release is taken on a clk edge.
- switch, input, 1, asynchronous step button; each rising edge captures one sample.
- data_in, input, DATA_W, sample word; must be stable while switch is high.
- frame_valid, output, 1, frame buffer full and offered to the FFT core.
- frame_ready, input, 1, pulse from the FFT core: frame consumed, buffer may be refilled.
- rd_addr, input, ADDR_W, core read index.
- rd_data, output, DATA_W, buffer[rd_addr], registered.
- sample_count, output, ADDR_W+1, number of samples captured in the current frame.
- overrun, output, 1, sticky flag: a press arrived while FULL.

Behaviour:
- Reset (reset=0), applied asynchronously:
  - state=FILL, wr_ptr=0, sample_count=0;
  - frame_valid=0, rd_data=0, overrun=0;
  - synchronizer and edge flops = 0.
  - Buffer contents are not cleared.
- Input synchronizer: switch passes through a 2-flop synchronizer (s1, s2), then a history flop s3. step = s2 & ~s3.
- Capture latency: if switch is first sampled high at edge k, the buffer write, wr_ptr increment and sample_count increment all occur at edge k+2.
- Press length: a press held for many cycles produces exactly one step. A press shorter than one clock period may be missed; this is accepted.
- FSM states: FILL, FULL.
- FILL state:
  - On step: buffer[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1 (wraps mod N_SAMPLES); sample_count <= sample_count+1.
  - When the write makes sample_count reach N_SAMPLES, state <= FULL and frame_valid <= 1 on that same edge.
- FULL state:
  - frame_valid is held at 1.
  - On step: no buffer write; overrun <= 1.
  - On frame_ready=1: state <= FILL, frame_valid <= 0, wr_ptr <= 0, sample_count <= 0, all on the next edge.
- Simultaneous step and frame_ready in FULL: the handshake is taken, overrun is set, and the step is dropped (not written into the new frame).
- frame_ready in FILL: ignored.
- overrun: clears only on reset.
- Read port: rd_data <= buffer[rd_addr] on every edge, in either state, so read latency is 1 cycle. A write and a read to the same address on the same edge return the old data.
- Reset mid-fill: the partial frame is discarded and sample_count returns to 0.
- Output timing: all outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: DEBOUNCE_EN.
- Defined:
  - s2 feeds a debounce counter.
  - The debounced level db toggles only after s2 differs from db for DEBOUNCE_CYCLES consecutive cycles; any agreement resets the counter.
  - step = db & ~db_prev.
  - Capture latency becomes k+2+DEBOUNCE_CYCLES.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are rejected.
- Not defined:
  - No counter is instantiated; DEBOUNCE_CYCLES is unused.
  - step is taken directly from s2/s3 with k+2 latency.

Test Plan:
- Reset then fill: hold reset=0 for 22 ns, then release. Apply 8 presses, each 22 ns high and 22 ns low, with data_in = 0x0011, 0x0022, …, 0x0088.
  - sample_count steps 1..8.
  - frame_valid rises on the edge of the 8th write.
  - Reading rd_addr 0..7 returns 0x0011..0x0088 with 1-cycle latency.
- Long press: hold switch high for 200 ns with data_in=0xBEEF.
  - Exactly one write occurs; sample_count increments by 1 only.
- Overrun: with the frame full, press once with data_in=0xDEAD.
  - overrun=1.
  - buffer[7] still reads 0x0088.
  - frame_valid stays 1.
- Handshake: pulse frame_ready for 1 cycle while FULL.
  - frame_valid=0 and sample_count=0 next cycle.
  - The next press (data_in=0x1234) writes rd_addr 0.
  - overrun remains 1.
- Reset mid-fill: after 3 presses, pulse reset low for 7 ns between clock edges.
  - Outputs clear immediately: sample_count=0, frame_valid=0, overrun=0.
  - The next press writes address 0.
- DEBOUNCE_EN defined, DEBOUNCE_CYCLES=16: a 50 ns switch glitch, then a 300 ns press.
  - The glitch causes no write.
  - The press writes once, 18 cycles after it is first sampled.
